mem_mod_sect_reg_par: RTL and testbench

- Parametrised successor to the serial memory module/sector register in the LVDC memory-addressing path.
- Holds separate instruction-side and data-side module, sector and duplex selections.
- Loads each selection serially from the HOP shift path, one bit per enable, and commits it atomically on frame completion.
- Drives registered, active-low, one-hot module selects plus the sector field per access. Supports N modules, duplex pairing, and serial readback of the current selection.

---
 rtl/mem_mod_sect_reg_par.sv | 132 +++++++++++++
 tb/tb_mem_mod_sect_reg_par.sv | 139 +++++++++++++
 2 files changed

// File: rtl/mem_mod_sect_reg_par.sv
// mem_mod_sect_reg_par: serially loaded instruction/data module, sector and duplex selection with one-hot selects and serial readback
module mem_mod_sect_reg_par #(
    parameter int MOD_BITS  = 2,
    parameter int SECT_BITS = 4,
    localparam int NMOD     = 2**MOD_BITS,
    localparam int FRAME    = SECT_BITS + MOD_BITS + 1
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    input  logic                 SER_START,
    input  logic                 SER_EN,
    input  logic                 SER_D,
    input  logic                 SER_TGT,
    output logic                 SER_ERR,
    input  logic                 ACC_REQ,
    input  logic                 ACC_I,
    output logic [NMOD-1:0]      MSEL_N,
    output logic [SECT_BITS-1:0] SECT,
    output logic                 DUP,
    input  logic                 SO_START,
    input  logic                 SO_TGT,
    output logic                 SO_D,
    output logic                 SO_VALID
);
    localparam int CW = $clog2(FRAME + 1);
    typedef enum logic {IDLE, LOAD} state_t;
    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d, so_cnt_q, so_cnt_d;
    logic                 tgt_q, tgt_d, err_q, err_d, commit;
    logic [FRAME-1:0]     sh_q, sh_d, i_frm_q, i_frm_d, d_frm_q, d_frm_d, so_sh_q, so_sh_d, sel, snap;
    logic [NMOD-1:0]      msel_q, msel_d;
    logic [SECT_BITS-1:0] sect_q, sect_d;
    logic [MOD_BITS-1:0]  mod;
    logic                 dup_q, dup_d, so_d_q, so_d_d, so_v_q, so_v_d;

    // Load FSM: frames are held as {dup, module, sector} and committed the edge after the last bit
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tgt_d   = tgt_q;
        sh_d    = sh_q;
        err_d   = 1'b0;
        i_frm_d = i_frm_q;
        d_frm_d = d_frm_q;
        commit  = state_q == LOAD && cnt_q == CW'(FRAME);
        if (commit) begin
            state_d = IDLE;
            if (tgt_q) d_frm_d = sh_q;
            else       i_frm_d = sh_q;
        end
        if (SER_START) begin
            err_d   = state_q == LOAD && cnt_q != '0 && !commit;
            state_d = LOAD;
            tgt_d   = SER_TGT;
            cnt_d   = CW'(SER_EN);
            sh_d    = FRAME'(SER_EN & SER_D);
        end else if (state_q == LOAD && SER_EN && !commit) begin
            sh_d[cnt_q] = SER_D;
            cnt_d       = cnt_q + CW'(1);
        end
    end

    // Access: registered active-low selects for one cycle, sector and duplex hold between accesses
    always_comb begin
        sel    = ACC_I ? i_frm_q : d_frm_q;
        mod    = sel[SECT_BITS +: MOD_BITS];
        msel_d = ACC_REQ ? ~((NMOD'(1) << mod) | (sel[FRAME-1] ? NMOD'(1) << (mod ^ MOD_BITS'(1)) : '0)) : '1;
        sect_d = ACC_REQ ? sel[SECT_BITS-1:0] : sect_q;
        dup_d  = ACC_REQ ? sel[FRAME-1] : dup_q;
    end

    // Readback: snapshot the pre-commit set, then shift it out LSB first
    always_comb begin
        snap     = SO_TGT ? d_frm_q : i_frm_q;
        so_sh_d  = so_sh_q >> 1;
        so_cnt_d = so_cnt_q;
        so_d_d   = 1'b0;
        so_v_d   = 1'b0;
        if (SO_START) begin
            so_sh_d  = snap >> 1;
            so_cnt_d = CW'(FRAME - 1);
            so_d_d   = snap[0];
            so_v_d   = 1'b1;
        end else if (so_cnt_q != '0) begin
            so_cnt_d = so_cnt_q - CW'(1);
            so_d_d   = so_sh_q[0];
            so_v_d   = 1'b1;
        end
    end

    // State registers
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            tgt_q    <= 1'b0;
            sh_q     <= '0;
            err_q    <= 1'b0;
            i_frm_q  <= '0;
            d_frm_q  <= '0;
            msel_q   <= '1;
            sect_q   <= '0;
            dup_q    <= 1'b0;
            so_sh_q  <= '0;
            so_cnt_q <= '0;
            so_d_q   <= 1'b0;
            so_v_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tgt_q    <= tgt_d;
            sh_q     <= sh_d;
            err_q    <= err_d;
            i_frm_q  <= i_frm_d;
            d_frm_q  <= d_frm_d;
            msel_q   <= msel_d;
            sect_q   <= sect_d;
            dup_q    <= dup_d;
            so_sh_q  <= so_sh_d;
            so_cnt_q <= so_cnt_d;
            so_d_q   <= so_d_d;
            so_v_q   <= so_v_d;
        end
    end

    assign SER_ERR  = err_q;
    assign MSEL_N   = msel_q;
    assign SECT     = sect_q;
    assign DUP      = dup_q;
    assign SO_D     = so_d_q;
    assign SO_VALID = so_v_q;
endmodule

// File: tb/tb_mem_mod_sect_reg_par.sv
// tb_mem_mod_sect_reg_par: directed checks of load, access, abort, collision, readback and reset
module tb_mem_mod_sect_reg_par;
    logic       CLK = 0, RSTN = 0, SER_START = 0, SER_EN = 0, SER_D = 0, SER_TGT = 0;
    logic       ACC_REQ = 0, ACC_I = 0, SO_START = 0, SO_TGT = 0;
    logic       SER_ERR, DUP, SO_D, SO_VALID;
    logic [3:0] MSEL_N, SECT;
    int         passed = 0, total = 0;
    localparam logic [6:0] F_A = 7'b0_10_1010;
    localparam logic [6:0] F_I = 7'b1_11_0101;
    localparam logic [6:0] F_P = 7'b0_01_0011;
    localparam logic [6:0] F_N = 7'b1_01_0011;

    always #5 CLK = ~CLK;

    mem_mod_sect_reg_par dut (
        .CLK(CLK), .RSTN(RSTN), .SER_START(SER_START), .SER_EN(SER_EN), .SER_D(SER_D),
        .SER_TGT(SER_TGT), .SER_ERR(SER_ERR), .ACC_REQ(ACC_REQ), .ACC_I(ACC_I),
        .MSEL_N(MSEL_N), .SECT(SECT), .DUP(DUP), .SO_START(SO_START), .SO_TGT(SO_TGT),
        .SO_D(SO_D), .SO_VALID(SO_VALID)
    );

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send(input logic tgt, input logic [6:0] f, input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            SER_START = (i == 0);
            SER_TGT   = tgt;
            SER_EN    = 1'b1;
            SER_D     = f[i];
            tick();
        end
        SER_START = 1'b0;
        SER_EN    = 1'b0;
    endtask

    task automatic access(input logic i);
        ACC_REQ = 1'b1;
        ACC_I   = i;
        tick();
        ACC_REQ = 1'b0;
    endtask

    task automatic expect_sel(input string tag, input logic [3:0] m, input logic [3:0] s, input logic d);
        check({tag, ".msel"}, 32'(MSEL_N), 32'(m));
        check({tag, ".sect"}, 32'(SECT), 32'(s));
        check({tag, ".dup"}, 32'(DUP), 32'(d));
    endtask

    task automatic readback(input logic tgt, input logic [6:0] f);
        SO_START = 1'b1;
        SO_TGT   = tgt;
        tick();
        SO_START = 1'b0;
        for (int i = 0; i < 7; i++) begin
            check($sformatf("rb%0d.valid%0d", tgt, i), 32'(SO_VALID), 32'd1);
            check($sformatf("rb%0d.d%0d", tgt, i), 32'(SO_D), 32'(f[i]));
            tick();
        end
        check($sformatf("rb%0d.done", tgt), 32'(SO_VALID), 32'd0);
    endtask

    initial begin
        tick();
        tick();
        expect_sel("rst", 4'b1111, 4'h0, 1'b0);
        check("rst.so_valid", 32'(SO_VALID), 32'd0);
        check("rst.ser_err", 32'(SER_ERR), 32'd0);
        RSTN = 1'b1;
        tick();
        access(1'b1);
        expect_sel("acc_rst", 4'b1110, 4'h0, 1'b0);
        tick();
        check("acc_idle.msel", 32'(MSEL_N), 32'hf);
        send(1'b1, F_A, 0, 7);
        tick();
        access(1'b0);
        expect_sel("data_a", 4'b1011, 4'hA, 1'b0);
        tick();
        check("hold.msel", 32'(MSEL_N), 32'hf);
        check("hold.sect", 32'(SECT), 32'hA);
        access(1'b1);
        expect_sel("instr_unch", 4'b1110, 4'h0, 1'b0);
        send(1'b0, F_I, 0, 7);
        tick();
        access(1'b1);
        expect_sel("instr_dup", 4'b0011, 4'h5, 1'b1);
        send(1'b1, F_P, 0, 3);
        check("partial.ser_err", 32'(SER_ERR), 32'd0);
        access(1'b0);
        expect_sel("partial_keep", 4'b1011, 4'hA, 1'b0);
        send(1'b1, F_N, 0, 1);
        check("abort.ser_err", 32'(SER_ERR), 32'd1);
        send(1'b1, F_N, 1, 2);
        check("abort.ser_err_end", 32'(SER_ERR), 32'd0);
        send(1'b1, F_N, 2, 7);
        tick();
        access(1'b0);
        expect_sel("abort_new", 4'b1100, 4'h3, 1'b1);
        send(1'b1, F_A, 0, 7);
        ACC_REQ = 1'b1;
        ACC_I   = 1'b0;
        tick();
        ACC_REQ = 1'b0;
        expect_sel("collide_old", 4'b1100, 4'h3, 1'b1);
        access(1'b0);
        expect_sel("collide_new", 4'b1011, 4'hA, 1'b0);
        readback(1'b1, F_A);
        readback(1'b0, F_I);
        SO_START = 1'b1;
        SO_TGT   = 1'b1;
        ACC_REQ  = 1'b1;
        ACC_I    = 1'b0;
        tick();
        SO_START = 1'b0;
        ACC_REQ  = 1'b0;
        check("pre_rst.msel", 32'(MSEL_N), 32'hb);
        check("pre_rst.so_valid", 32'(SO_VALID), 32'd1);
        RSTN = 1'b0;
        #1;
        expect_sel("async_rst", 4'b1111, 4'h0, 1'b0);
        check("async_rst.so_valid", 32'(SO_VALID), 32'd0);
        tick();
        RSTN = 1'b1;
        tick();
        access(1'b0);
        expect_sel("post_rst", 4'b1110, 4'h0, 1'b0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
